ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Time-multiplexed seven-segment display driver; sits directly downstream of the SSD clock divider and consumes its slow divided clock as a scan-rate input.
- Synchronises and edge-detects that scan clock in the fast system domain and advances a digit scan on each rising edge.
- Per digit: decodes a hex nibble to active-low segments and drives active-low anodes, with an anti-ghosting blank interval, frame-aligned value latching and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- BLANK_CYCLES, 16, clk_in cycles all anodes are held off after each digit change (0 disables blanking).

Ports:
- clk_in  input  1  system clock; sole clock of the block.
- rst  input  1  asynchronous, active-high reset.
- ssd_clk  input  1  divided scan clock from the SSD clock divider; treated as an asynchronous data signal.
- value_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 = rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- blank_lz  input  1  enable leading-zero blanking.
- an  output  NUM_DIGITS  anode enables, active-low, registered.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low (seg[0]=a), registered.
- dp  output  1  decimal point cathode, active-low, registered.
- frame_start  output  1  one-cycle pulse when the scan wraps to digit 0, registered.

Behaviour:
- Clock/reset: single clock clk_in. rst is asynchronous and active-high; when asserted mid-scan, all state clears immediately.
- Reset values: an all ones, seg 7'h7F, dp 1, frame_start 0, digit_idx 0, blank_cnt 0, sync flops 0, shadow value 0, shadow dp 0, shadow blank_lz 1.
- Synchroniser: ssd_clk passes through two flops (s1, s2), and s3 holds the previous s2. tick = s2 & ~s3.
  - Latency from an ssd_clk rise to tick is 2-3 clk_in cycles.
  - ssd_clk high at reset release counts as one rising edge.
- On a tick at edge T:
  - digit_idx <= (digit_idx == NUM_DIGITS-1) ? 0 : digit_idx+1.
  - blank_cnt <= BLANK_CYCLES.
  - On wrap only: shadow regs <= value_in, dp_in, blank_lz, and frame_start <= 1 at edge T for exactly one cycle. frame_start is 0 at every other edge.
- blank_cnt decrements by 1 each edge while nonzero and no tick occurs. A tick reloads it, so a tick during blanking restarts the interval.
- Output register, every edge, computed from the pre-edge state:
  - an = all ones if blank_cnt != 0, else all ones with bit digit_idx cleared.
  - seg = decode(shadow nibble[digit_idx]), or 7'h7F if that digit is blanked.
  - dp = ~shadow_dp[digit_idx].
- Resulting timing: after a tick at edge T, seg/dp show the new digit from edge T+1 and its anode asserts at edge T+BLANK_CYCLES+1. With BLANK_CYCLES=0 the anode asserts at T+1.
- Leading-zero blanking: digit i (i ≥ 1) is blanked if shadow blank_lz=1 and shadow nibbles i through NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Frame-tear rule: value_in, dp_in and blank_lz changing mid-frame do not affect displayed digits until the next wrap.
- Without ssd_clk edges the current digit stays lit indefinitely (no internal timeout).

Test Plan (NUM_DIGITS=4, BLANK_CYCLES=4):
1. Reset held, ssd_clk toggling -> an=4'b1111, seg=7'h7F, dp=1, frame_start=0. One cycle after release with ssd_clk low -> an=4'b1110, seg=1000000 (shadow zero, digit 0 shows "0").
2. value_in=16'h12AF, dp_in=0, blank_lz=0; run ssd_clk until the first frame_start; next 4 ticks -> digits 0..3 show F(0001110), A(0001000), 2(0100100), 1(1111001) on an=1110, 1101, 1011, 0111. frame_start pulses once every 4 ticks.
3. After a single tick at edge T -> an=1111 at edges T+1..T+4, target anode low at T+5. seg takes its new value at T+1.
4. value_in=16'h0007, blank_lz=1, dp_in=4'b0100 -> digit 0 shows 7 (1111000); digits 1 and 3 show seg=7'h7F, dp=1; digit 2 shows seg=7'h7F, dp=0.
5. Change value_in from 16'h1111 to 16'h2222 while digit 2 is displayed -> digits 2 and 3 still show 1; 2 appears only after the next frame_start.
6. Assert rst asynchronously between clock edges during the blank interval -> an=1111, seg=7'h7F, dp=1 immediately without a clock edge. After release the scan restarts at digit 0.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver. The divided scan clock is
// synchronised into clk_in and each rising edge advances to the next digit.
// All anodes are held off for a short interval after each change to avoid
// ghosting. Displayed values are latched once per frame, when the scan wraps
// back to digit 0.
`timescale 1ns/1ps
module ssd_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    ssd_clk,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES);

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic                    s1_q, s2_q, s3_q;
  logic                    tick;
  logic                    wrap;
  logic [IdxW-1:0]         digit_idx_q, digit_idx_d;
  logic [CntW-1:0]         blank_cnt_q, blank_cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    shadow_lz_q, shadow_lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;

  assign tick = s2_q & ~s3_q;
  assign wrap = tick && (digit_idx_q == LastIdx);

  // Leading-zero mask: digit i blanks when it and every digit above it are zero
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (shadow_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = (i != 0) && shadow_lz_q && all_zero;
    end
  end

  // Select the shadow nibble, dp and blank flag of the current digit
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) == digit_idx_q) begin
        cur_nib   = shadow_val_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  // Next-state for scan position, blank counter, frame shadow and outputs
  always_comb begin
    digit_idx_d  = digit_idx_q;
    blank_cnt_d  = blank_cnt_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_lz_d  = shadow_lz_q;
    fs_d         = wrap;

    if (tick) begin
      digit_idx_d = wrap ? '0 : digit_idx_q + 1'b1;
      blank_cnt_d = BlankLoad;
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - 1'b1;
    end

    // Latch display data only at frame boundaries so a frame never tears
    if (wrap) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
      shadow_lz_d  = blank_lz;
    end

    // Outputs reflect pre-edge state: new digit appears one edge after the tick
    an_d = '1;
    if (blank_cnt_q == '0) an_d[digit_idx_q] = 1'b0;
    seg_d = cur_blank ? 7'h7F : decode(cur_nib);
    dp_d  = ~cur_dp;
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      digit_idx_q  <= '0;
      blank_cnt_q  <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_lz_q  <= 1'b1;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      s1_q         <= ssd_clk;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      digit_idx_q  <= digit_idx_d;
      blank_cnt_q  <= blank_cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lz_q  <= shadow_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with NUM_DIGITS=4, BLANK_CYCLES=4.
`timescale 1ns/1ps
module tb_ssd_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        ssd_clk = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int compared = 0;
  int mismatched = 0;
  logic fs_seen;

  ssd_scan_driver #(
    .NUM_DIGITS  (4),
    .BLANK_CYCLES(4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .ssd_clk    (ssd_clk),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  // One scan step: rise lands as a tick at the 3rd posedge (T); frame_start is
  // sampled just after T, then returns just after T+5 when the anode is lit.
  task automatic step_tick();
    @(negedge clk_in) ssd_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 fs_seen = frame_start;
    @(negedge clk_in) ssd_clk = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
  endtask

  task automatic seek_frame(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step_tick();
      found = fs_seen;
    end
    compared++;
    if (found !== 1'b1) begin
      mismatched++;
      $display("FAIL %s: frame_start seen=%b required=1 within 8 ticks", name, found);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #7 ssd_clk = ~ssd_clk;
      compared++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: an=%b seg=%h dp=%b fs=%b required an=1111 seg=7f dp=1 fs=0",
                 an, seg, dp, frame_start);
      end
    end
    ssd_clk = 1'b0;
    @(negedge clk_in) rst = 1'b0;
    @(posedge clk_in);
    #1;
    compared++;
    if (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1 || frame_start !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: an=%b seg=%h dp=%b fs=%b required an=1110 seg=40 dp=1 fs=0",
               an, seg, dp, frame_start);
    end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an [4];
    exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    value_in = 16'h12AF;
    dp_in = 4'h0;
    blank_lz = 1'b0;
    seek_frame("scan_first_frame");
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        step_tick();
        compared++;
        if (fs_seen !== 1'b0) begin
          mismatched++;
          $display("FAIL scan_fs_d%0d: frame_start=%b required=0", d, fs_seen);
        end
      end
      compared++;
      if (an !== exp_an[d] || seg !== exp_seg[d] || dp !== 1'b1 || frame_start !== 1'b0) begin
        mismatched++;
        $display("FAIL scan_d%0d: an=%b seg=%h dp=%b fs=%b required an=%b seg=%h dp=1 fs=0",
                 d, an, seg, dp, frame_start, exp_an[d], exp_seg[d]);
      end
    end
    step_tick();
    compared++;
    if (fs_seen !== 1'b1 || an !== 4'b1110 || seg !== 7'h0E) begin
      mismatched++;
      $display("FAIL scan_wrap: fs=%b an=%b seg=%h required fs=1 an=1110 seg=0e",
               fs_seen, an, seg);
    end
  endtask

  task automatic test_blank_timing();
    @(negedge clk_in) ssd_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) ssd_clk = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_in);
      #1;
      compared++;
      if (an !== 4'b1111) begin
        mismatched++;
        $display("FAIL blank_T+%0d: an=%b required=1111", k, an);
      end
      if (k == 1) begin
        compared++;
        if (seg !== 7'h08) begin
          mismatched++;
          $display("FAIL blank_seg_T+1: seg=%h required=08", seg);
        end
      end
    end
    @(posedge clk_in);
    #1;
    compared++;
    if (an !== 4'b1101 || seg !== 7'h08) begin
      mismatched++;
      $display("FAIL blank_T+5: an=%b seg=%h required an=1101 seg=08", an, seg);
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    logic [3:0] exp_an [4];
    exp_seg = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    value_in = 16'h0007;
    blank_lz = 1'b1;
    dp_in = 4'b0100;
    seek_frame("lz_frame");
    for (int d = 0; d < 4; d++) begin
      if (d != 0) step_tick();
      compared++;
      if (an !== exp_an[d] || seg !== exp_seg[d] || dp !== exp_dp[d]) begin
        mismatched++;
        $display("FAIL lz_d%0d: an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                 d, an, seg, dp, exp_an[d], exp_seg[d], exp_dp[d]);
      end
    end
  endtask

  task automatic test_frame_tear();
    value_in = 16'h1111;
    dp_in = 4'h0;
    blank_lz = 1'b0;
    step_tick();
    compared++;
    if (fs_seen !== 1'b1 || an !== 4'b1110 || seg !== 7'h79) begin
      mismatched++;
      $display("FAIL tear_wrap: fs=%b an=%b seg=%h required fs=1 an=1110 seg=79",
               fs_seen, an, seg);
    end
    step_tick();
    step_tick();
    value_in = 16'h2222;
    @(posedge clk_in);
    #1;
    compared++;
    if (an !== 4'b1011 || seg !== 7'h79) begin
      mismatched++;
      $display("FAIL tear_d2: an=%b seg=%h required an=1011 seg=79", an, seg);
    end
    step_tick();
    compared++;
    if (an !== 4'b0111 || seg !== 7'h79) begin
      mismatched++;
      $display("FAIL tear_d3: an=%b seg=%h required an=0111 seg=79", an, seg);
    end
    step_tick();
    compared++;
    if (fs_seen !== 1'b1 || an !== 4'b1110 || seg !== 7'h24) begin
      mismatched++;
      $display("FAIL tear_next_frame: fs=%b an=%b seg=%h required fs=1 an=1110 seg=24",
               fs_seen, an, seg);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_in) ssd_clk = 1'b1;
    repeat (3) @(posedge clk_in);
    @(posedge clk_in);
    #1;
    compared++;
    if (an !== 4'b1111 || seg !== 7'h24) begin
      mismatched++;
      $display("FAIL areset_pre: an=%b seg=%h required an=1111 seg=24", an, seg);
    end
    #3 rst = 1'b1;
    #1;
    compared++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      mismatched++;
      $display("FAIL areset_now: an=%b seg=%h dp=%b fs=%b required an=1111 seg=7f dp=1 fs=0",
               an, seg, dp, frame_start);
    end
    ssd_clk = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst = 1'b0;
    @(posedge clk_in);
    #1;
    compared++;
    if (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
      mismatched++;
      $display("FAIL areset_restart: an=%b seg=%h dp=%b required an=1110 seg=40 dp=1",
               an, seg, dp);
    end
    // Shadow blank_lz resets to 1 with zero value, so digit 1 is blank
    step_tick();
    compared++;
    if (an !== 4'b1101 || seg !== 7'h7F || fs_seen !== 1'b0) begin
      mismatched++;
      $display("FAIL areset_d1: an=%b seg=%h fs=%b required an=1101 seg=7f fs=0",
               an, seg, fs_seen);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_timing();
    test_lz_blank();
    test_frame_tear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
